spi_read_sequencer: RTL and testbench

//  Upstream command stage for spi_flash_read. Accepts one read request {start,end,mode} at a time.

---
 rtl/spi_read_sequencer_if.sv | 31 +++
 rtl/spi_read_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_spi_read_sequencer.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_read_sequencer_if.sv
// Bundle of command, reader-launch and status signals of spi_read_sequencer.
// master = host/reader side, slave = the sequencer itself.
interface spi_read_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_start_addr;
  logic [31:0] cmd_end_addr;
  logic [1:0]  cmd_mode;
  logic        rd_start_flag;
  logic        rd_read_req;
  logic [31:0] rd_start_addr;
  logic [31:0] rd_end_addr;
  logic [1:0]  rd_mode;
  logic        rd_switch_die;
  logic        read_finish;
  logic        seq_busy;
  logic        seq_done;
  logic        seq_error;

  modport master (
    output cmd_valid, cmd_start_addr, cmd_end_addr, cmd_mode, read_finish,
    input  cmd_ready, rd_start_flag, rd_read_req, rd_start_addr, rd_end_addr,
           rd_mode, rd_switch_die, seq_busy, seq_done, seq_error
  );

  modport slave (
    input  cmd_valid, cmd_start_addr, cmd_end_addr, cmd_mode, read_finish,
    output cmd_ready, rd_start_flag, rd_read_req, rd_start_addr, rd_end_addr,
           rd_mode, rd_switch_die, seq_busy, seq_done, seq_error
  );
endinterface

// File: rtl/spi_read_sequencer.sv
// Splits a {start,end,mode} read request into die-aligned segments and launches
// each into spi_flash_read, supervising its read_finish handshake with timeouts.
module spi_read_sequencer #(
  parameter logic [31:0] DIE_SIZE     = 32'h0200_0000,
  parameter logic [15:0] ACK_TIMEOUT  = 16'd64,
  parameter logic [31:0] DONE_TIMEOUT = 32'd50_000_000
) (
  input  logic                system_clk,
  input  logic                system_reset,
  spi_read_sequencer_if.slave bus
);
  localparam int          DIE_SHIFT = $clog2(DIE_SIZE);
  localparam logic [31:0] DIE_MASK  = DIE_SIZE - 32'd1;
  localparam logic [31:0] ACK_LAST  = {16'd0, ACK_TIMEOUT} - 32'd1;
  localparam logic [31:0] DONE_LAST = DONE_TIMEOUT - 32'd1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SPLIT     = 3'd1,
    LAUNCH    = 3'd2,
    WAIT_ACK  = 3'd3,
    WAIT_DONE = 3'd4,
    ERR       = 3'd5
  } state_t;

  state_t      state_r, state_s;
  logic [31:0] cur_r, cur_s, end_r, end_s, last_die_r, last_die_s, cnt_r, cnt_s;
  logic [31:0] start_addr_r, start_addr_s, end_addr_r, end_addr_s;
  logic [1:0]  mode_r, mode_s;
  logic        switch_die_r, switch_die_s, start_flag_r, start_flag_s;
  logic        read_req_r, read_req_s, cmd_ready_r, cmd_ready_s;
  logic        busy_r, busy_s, done_r, done_s, error_r, error_s;
  logic [31:0] bnd_s, seg_end_s, die_s;

  // The die boundary is the current address with all in-die offset bits set.
  assign bnd_s     = cur_r | DIE_MASK;
  assign seg_end_s = (end_r < bnd_s) ? end_r : bnd_s;
  assign die_s     = cur_r >> DIE_SHIFT;

  // Next-state and next-register values for every sequencer register.
  always_comb begin
    state_s      = state_r;
    cur_s        = cur_r;
    end_s        = end_r;
    mode_s       = mode_r;
    last_die_s   = last_die_r;
    start_addr_s = start_addr_r;
    end_addr_s   = end_addr_r;
    switch_die_s = switch_die_r;
    read_req_s   = read_req_r;
    start_flag_s = 1'b0;
    done_s       = 1'b0;
    error_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.cmd_valid) begin
          if (bus.cmd_end_addr < bus.cmd_start_addr) begin
            error_s = 1'b1;
          end else begin
            cur_s   = bus.cmd_start_addr;
            end_s   = bus.cmd_end_addr;
            mode_s  = bus.cmd_mode;
            state_s = SPLIT;
          end
        end else begin
          state_s = IDLE;
        end
      end
      SPLIT: begin
        start_addr_s = cur_r;
        end_addr_s   = seg_end_s;
        switch_die_s = (die_s != last_die_r);
        last_die_s   = die_s;
        start_flag_s = 1'b1;
        read_req_s   = 1'b1;
        state_s      = LAUNCH;
      end
      LAUNCH: begin
        state_s = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (!bus.read_finish) begin
          state_s = WAIT_DONE;
        end else if (cnt_r >= ACK_LAST) begin
          read_req_s = 1'b0;
          error_s    = 1'b1;
          state_s    = ERR;
        end else begin
          state_s = WAIT_ACK;
        end
      end
      WAIT_DONE: begin
        if (bus.read_finish) begin
          read_req_s = 1'b0;
          // Advance only while seg_end < end, so an end of all-ones never wraps.
          if (end_addr_r == end_r) begin
            done_s  = 1'b1;
            state_s = IDLE;
          end else begin
            cur_s   = end_addr_r + 32'd1;
            state_s = SPLIT;
          end
        end else if (cnt_r >= DONE_LAST) begin
          read_req_s = 1'b0;
          error_s    = 1'b1;
          state_s    = ERR;
        end else begin
          state_s = WAIT_DONE;
        end
      end
      ERR: begin
        state_s = IDLE;
      end
      default: begin
        read_req_s = 1'b0;
        state_s    = IDLE;
      end
    endcase

    if (state_s != state_r) begin
      cnt_s = 32'd0;
    end else if ((state_r == WAIT_ACK) || (state_r == WAIT_DONE)) begin
      cnt_s = cnt_r + 32'd1;
    end else begin
      cnt_s = 32'd0;
    end
    cmd_ready_s = (state_s == IDLE);
    busy_s      = (state_s != IDLE);
  end

  // State register.
  always_ff @(posedge system_clk or posedge system_reset) begin
    if (system_reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath, timeout counter and registered outputs.
  always_ff @(posedge system_clk or posedge system_reset) begin
    if (system_reset) begin
      cur_r        <= 32'd0;
      end_r        <= 32'd0;
      mode_r       <= 2'd0;
      last_die_r   <= 32'd0;
      cnt_r        <= 32'd0;
      start_addr_r <= 32'd0;
      end_addr_r   <= 32'd0;
      switch_die_r <= 1'b0;
      start_flag_r <= 1'b0;
      read_req_r   <= 1'b0;
      cmd_ready_r  <= 1'b1;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
    end else begin
      cur_r        <= cur_s;
      end_r        <= end_s;
      mode_r       <= mode_s;
      last_die_r   <= last_die_s;
      cnt_r        <= cnt_s;
      start_addr_r <= start_addr_s;
      end_addr_r   <= end_addr_s;
      switch_die_r <= switch_die_s;
      start_flag_r <= start_flag_s;
      read_req_r   <= read_req_s;
      cmd_ready_r  <= cmd_ready_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
      error_r      <= error_s;
    end
  end

  assign bus.cmd_ready     = cmd_ready_r;
  assign bus.rd_start_flag = start_flag_r;
  assign bus.rd_read_req   = read_req_r;
  assign bus.rd_start_addr = start_addr_r;
  assign bus.rd_end_addr   = end_addr_r;
  assign bus.rd_mode       = mode_r;
  assign bus.rd_switch_die = switch_die_r;
  assign bus.seq_busy      = busy_r;
  assign bus.seq_done      = done_r;
  assign bus.seq_error     = error_r;
endmodule

// File: tb/tb_spi_read_sequencer.sv
// Scoreboard bench for spi_read_sequencer: a request-level model predicts segments,
// done and error events with their cycle timing; a monitor pops and compares them.
module tb_spi_read_sequencer;
  localparam logic [31:0]     DIE       = 32'h0200_0000;
  localparam longint unsigned DIE_BYTES = 64'h0000_0000_0200_0000;
  localparam int              ACK_T     = 64;
  localparam int              DONE_T    = 200;

  typedef struct {
    int          kind;   // 0 launch, 1 done, 2 bad request, 3 ack timeout, 4 done timeout
    logic [31:0] s;
    logic [31:0] e;
    logic [1:0]  m;
    logic        sw;
    bit          first;
  } exp_t;

  logic system_clk = 1'b0;
  logic system_reset;
  always #5 system_clk = ~system_clk;

  spi_read_sequencer_if bus();

  spi_read_sequencer #(
    .DIE_SIZE    (DIE),
    .ACK_TIMEOUT (16'd64),
    .DONE_TIMEOUT(32'd200)
  ) dut (
    .system_clk  (system_clk),
    .system_reset(system_reset),
    .bus         (bus)
  );

  int              checks = 0;
  int              errors = 0;
  int              cyc = 0;
  exp_t            sbq[$];
  int              acc_cyc = 0, flag_cyc = 0, rise_cyc = 0, fall_cyc = 0;
  int              flag_count = 0;
  logic            prev_rf = 1'b1;
  int              rdr_mode = 0, ack_dly = 1, fin_dly = 1;
  bit              rdr_busy = 1'b0;
  longint unsigned model_last_die = 0;
  exp_t            mx;
  int              lat_exp;

  always @(posedge system_clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input string detail);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s %s", name, detail);
    end
  endtask

  // Reader model: drops read_finish ack_dly cycles after a launch, raises it fin_dly later.
  initial begin
    bus.read_finish = 1'b1;
    forever begin
      @(negedge system_clk);
      if (bus.rd_start_flag && !system_reset) begin
        rdr_busy = 1'b1;
        if (rdr_mode != 1) begin
          repeat (ack_dly) @(negedge system_clk);
          bus.read_finish = 1'b0;
          if (rdr_mode == 2) begin
            for (int i = 0; i < 4 * DONE_T && bus.rd_read_req; i++) @(negedge system_clk);
          end else begin
            repeat (fin_dly) @(negedge system_clk);
          end
          bus.read_finish = 1'b1;
        end
        rdr_busy = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a launch, done or error.
  always @(posedge system_clk) begin
    #1;
    if (!system_reset) begin
      if (prev_rf && !bus.read_finish) fall_cyc = cyc - 1;
      if (!prev_rf && bus.read_finish) rise_cyc = cyc - 1;
      if (bus.rd_start_flag) begin
        flag_count++;
        flag_cyc = cyc;
        if (sbq.size() == 0) begin
          check(1'b0, "unexpected_launch", $sformatf("got launch %h..%h exp no event", bus.rd_start_addr, bus.rd_end_addr));
        end else begin
          mx = sbq.pop_front();
          lat_exp = mx.first ? acc_cyc + 2 : rise_cyc + 2;
          check(mx.kind == 0 && bus.rd_start_addr == mx.s && bus.rd_end_addr == mx.e &&
                bus.rd_mode == mx.m && bus.rd_switch_die == mx.sw && bus.rd_read_req && cyc == lat_exp,
                "launch", $sformatf("got s=%h e=%h m=%0d sw=%0b req=%0b cyc=%0d exp kind=%0d s=%h e=%h m=%0d sw=%0b req=1 cyc=%0d",
                bus.rd_start_addr, bus.rd_end_addr, bus.rd_mode, bus.rd_switch_die, bus.rd_read_req, cyc,
                mx.kind, mx.s, mx.e, mx.m, mx.sw, lat_exp));
        end
      end
      if (bus.seq_done) begin
        if (sbq.size() == 0) begin
          check(1'b0, "unexpected_done", "got seq_done exp no event");
        end else begin
          mx = sbq.pop_front();
          check(mx.kind == 1 && cyc == rise_cyc + 1 && !bus.rd_read_req, "done",
                $sformatf("got kind=1 cyc=%0d req=%0b exp kind=%0d cyc=%0d req=0", cyc, bus.rd_read_req, mx.kind, rise_cyc + 1));
        end
      end
      if (bus.seq_error) begin
        if (sbq.size() == 0) begin
          check(1'b0, "unexpected_error", "got seq_error exp no event");
        end else begin
          mx = sbq.pop_front();
          case (mx.kind)
            2:       lat_exp = acc_cyc + 1;
            3:       lat_exp = flag_cyc + ACK_T + 1;
            4:       lat_exp = fall_cyc + DONE_T + 1;
            default: lat_exp = -1;
          endcase
          check(mx.kind >= 2 && cyc == lat_exp && !bus.rd_read_req, "error",
                $sformatf("got error cyc=%0d req=%0b exp kind=%0d cyc=%0d req=0", cyc, bus.rd_read_req, mx.kind, lat_exp));
        end
      end
    end
    prev_rf = bus.read_finish;
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (n < 3000 && !(sbq.size() == 0 && !bus.seq_busy && !rdr_busy && bus.read_finish)) begin
      @(posedge system_clk);
      #3;
      n++;
    end
    if (n >= 3000) begin
      check(1'b0, "idle_timeout", $sformatf("got pending=%0d busy=%0b exp pending=0 busy=0", sbq.size(), bus.seq_busy));
      sbq.delete();
    end
  endtask

  // Predicts the event list from the request, then drives it (plus a poke while busy).
  task automatic issue(input logic [31:0] s, input logic [31:0] e, input logic [1:0] m,
                       input int rmode, input int ad, input int fd, input bit do_wait);
    longint unsigned cur, bnd, seg_end, endv, die;
    exp_t            x;
    bit              first, fin;
    wait_idle();
    rdr_mode = rmode;
    ack_dly  = ad;
    fin_dly  = fd;
    endv = {32'd0, e};
    cur  = {32'd0, s};
    x.s = 32'd0; x.e = 32'd0; x.m = m; x.sw = 1'b0; x.first = 1'b0;
    if (e < s) begin
      x.kind = 2;
      sbq.push_back(x);
    end else begin
      first = 1'b1;
      fin   = 1'b0;
      while (!fin) begin
        die     = cur / DIE_BYTES;
        bnd     = (die + 1) * DIE_BYTES - 1;
        seg_end = (endv < bnd) ? endv : bnd;
        x.kind = 0; x.s = cur[31:0]; x.e = seg_end[31:0]; x.m = m;
        x.sw = (die != model_last_die); x.first = first;
        sbq.push_back(x);
        model_last_die = die;
        if (rmode == 1) begin
          x.kind = 3; sbq.push_back(x); fin = 1'b1;
        end else if (rmode == 2) begin
          x.kind = 4; sbq.push_back(x); fin = 1'b1;
        end else if (seg_end == endv) begin
          x.kind = 1; sbq.push_back(x); fin = 1'b1;
        end else begin
          cur   = seg_end + 1;
          first = 1'b0;
        end
      end
    end
    @(negedge system_clk);
    bus.cmd_valid = 1'b1; bus.cmd_start_addr = s; bus.cmd_end_addr = e; bus.cmd_mode = m;
    acc_cyc = cyc;
    @(negedge system_clk);
    bus.cmd_valid = 1'b0;
    if (!(e < s)) begin
      @(negedge system_clk);
      bus.cmd_valid = 1'b1; bus.cmd_start_addr = $urandom; bus.cmd_end_addr = $urandom;
      @(negedge system_clk);
      bus.cmd_valid = 1'b0;
    end
    if (do_wait) wait_idle();
  endtask

  task automatic run_random(input int count);
    longint unsigned sv, ev, d, off, len;
    logic [1:0]      mm;
    for (int k = 0; k < count; k++) begin
      d   = $urandom_range(0, 127);
      off = $urandom_range(0, 700);
      sv  = (d + 1) * DIE_BYTES - off;
      if (sv > 64'h0000_0000_FFFF_FFFF) sv = 64'h0000_0000_FFFF_FFFF;
      if ($urandom_range(0, 1) == 1) len = $urandom_range(0, 2000);
      else                           len = $urandom_range(0, 32'h0600_0000);
      ev = sv + len;
      if (ev > 64'h0000_0000_FFFF_FFFF) ev = 64'h0000_0000_FFFF_FFFF;
      if ($urandom_range(0, 9) == 0) ev = sv - 1 - $urandom_range(0, 300);
      mm = 2'($urandom_range(0, 3));
      issue(sv[31:0], ev[31:0], mm, 0, $urandom_range(1, 5), $urandom_range(1, 30), 1'b1);
    end
  endtask

  initial begin
    int fc, n;
    system_reset = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_start_addr = 32'd0; bus.cmd_end_addr = 32'd0; bus.cmd_mode = 2'd0;
    repeat (3) @(negedge system_clk);
    check({bus.cmd_ready, bus.seq_busy, bus.seq_done, bus.seq_error, bus.rd_start_flag, bus.rd_read_req,
           bus.rd_switch_die, bus.rd_mode, bus.rd_start_addr, bus.rd_end_addr} == {1'b1, 72'd0},
          "reset_state", $sformatf("got ready=%0b busy=%0b req=%0b sa=%h ea=%h exp ready=1 others 0",
          bus.cmd_ready, bus.seq_busy, bus.rd_read_req, bus.rd_start_addr, bus.rd_end_addr));
    system_reset = 1'b0;
    repeat (2) @(negedge system_clk);

    issue(32'h0000_0100, 32'h0000_01FF, 2'd1, 0, 3, 20, 1'b1);
    issue(32'h01FF_FF00, 32'h0200_00FF, 2'd2, 0, 2, 10, 1'b1);
    fc = flag_count;
    issue(32'h0000_0500, 32'h0000_04FF, 2'd0, 0, 1, 1, 1'b1);
    check(flag_count == fc, "bad_req_no_launch", $sformatf("got launches=%0d exp %0d", flag_count - fc, 0));
    issue(32'h0000_1000, 32'h0000_1FFF, 2'd3, 1, 1, 1, 1'b1);
    check(!bus.rd_read_req && bus.cmd_ready && !bus.seq_busy, "after_ack_timeout",
          $sformatf("got req=%0b ready=%0b busy=%0b exp req=0 ready=1 busy=0", bus.rd_read_req, bus.cmd_ready, bus.seq_busy));
    issue(32'h3000_0000, 32'h3000_0010, 2'd0, 2, 2, 1, 1'b1);

    // Reset in the middle of the first segment's WAIT_DONE.
    issue(32'h01FF_FF00, 32'h0200_00FF, 2'd2, 0, 2, 40, 1'b0);
    n = 0;
    while (n < 200 && bus.read_finish) begin
      @(negedge system_clk);
      n++;
    end
    check(n < 200, "reader_ack_seen", $sformatf("got wait=%0d exp <200", n));
    repeat (5) @(negedge system_clk);
    #2;
    system_reset = 1'b1;
    #1;
    check(!bus.rd_read_req && !bus.seq_busy && bus.cmd_ready, "async_reset",
          $sformatf("got req=%0b busy=%0b ready=%0b exp req=0 busy=0 ready=1", bus.rd_read_req, bus.seq_busy, bus.cmd_ready));
    sbq.delete();
    model_last_die = 0;
    @(negedge system_clk);
    system_reset = 1'b0;
    wait_idle();
    issue(32'h01FF_FF00, 32'h0200_00FF, 2'd2, 0, 1, 5, 1'b1);

    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd3, 0, 2, 4, 1'b1);
    run_random(25);
    wait_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog got no finish exp finish before 800000ns");
    $fatal(1, "watchdog");
  end
endmodule
